// File: rtl/alu_led_reader.sv
// Reads a 32-bit ALU result and its ZF/OF flags through the ALU top's 8-bit LED port.
// It steps the lane select through the four byte lanes and then the flag lane.
module alu_led_reader #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op_in,
    input  logic [2:0]  ab_in,
    input  logic [7:0]  LED,
    output logic [2:0]  ALU_OP,
    output logic [2:0]  AB_SW,
    output logic [2:0]  F_LED_SW,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zf,
    output logic        of
);

    localparam int unsigned   CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0]    LANE_FLAGS = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [2:0]        ab_sw_q, ab_sw_d;
    logic [2:0]        f_led_sw_q, f_led_sw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic              zf_q, zf_d;
    logic              of_q, of_d;
    logic [31:0]       shadow_q, shadow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_SETTLE;
            S_SETTLE:  if (cnt_q == '0) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (f_led_sw_q == LANE_FLAGS) ? S_DONE : S_SETTLE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // The flag lane capture commits the whole read, so done and result appear together.
    always_comb begin
        cnt_d      = cnt_q;
        alu_op_d   = alu_op_q;
        ab_sw_d    = ab_sw_q;
        f_led_sw_d = f_led_sw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        zf_d       = zf_q;
        of_d       = of_q;
        shadow_d   = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    alu_op_d   = op_in;
                    ab_sw_d    = ab_in;
                    f_led_sw_d = 3'b000;
                    cnt_d      = CNT_RELOAD;
                    busy_d     = 1'b1;
                    shadow_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            S_CAPTURE: begin
                if (f_led_sw_q == LANE_FLAGS) begin
                    result_d   = shadow_q;
                    zf_d       = LED[7];
                    of_d       = LED[0];
                    done_d     = 1'b1;
                    f_led_sw_d = 3'b000;
                end else begin
                    shadow_d[{f_led_sw_q[1:0], 3'b000} +: 8] = LED;
                    f_led_sw_d = f_led_sw_q + 3'd1;
                    cnt_d      = CNT_RELOAD;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            alu_op_q   <= 3'b000;
            ab_sw_q    <= 3'b000;
            f_led_sw_q <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zf_q       <= 1'b0;
            of_q       <= 1'b0;
            shadow_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            alu_op_q   <= alu_op_d;
            ab_sw_q    <= ab_sw_d;
            f_led_sw_q <= f_led_sw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zf_q       <= zf_d;
            of_q       <= of_d;
            shadow_q   <= shadow_d;
        end
    end

    assign ALU_OP   = alu_op_q;
    assign AB_SW    = ab_sw_q;
    assign F_LED_SW = f_led_sw_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zf       = zf_q;
    assign of       = of_q;

endmodule

// File: tb/tb_alu_led_reader.sv
// Bench for alu_led_reader: an ALU-top stub drives LED, and a cycle-count reference model
// predicts every output on every clock.
module tb_alu_led_reader;

    localparam int SETTLE_CYC = 4;
    localparam int LANE_CYC   = SETTLE_CYC + 1;
    localparam int READ_CYC   = 5 * LANE_CYC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op_in, ab_in;
    logic [7:0]  LED;
    logic [2:0]  ALU_OP, AB_SW, F_LED_SW;
    logic        busy, done;
    logic [31:0] result;
    logic        zf, of;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [31:0] stub_f = '0;
    logic        stub_zf = 1'b0, stub_of = 1'b0;
    logic [5:0]  stub_mid = '0;
    logic        noise_en = 1'b0, noise_on = 1'b0;
    logic [7:0]  noise_val = '0, led_true;

    logic        m_busy = 1'b0;
    int          m_k = 0;
    int          m_ndone = 0;
    logic [2:0]  m_op = '0, m_ab = '0;
    logic [31:0] m_acc = '0, m_res = '0;
    logic        m_zf = 1'b0, m_of = 1'b0;

    alu_led_reader #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in), .ab_in(ab_in),
        .LED(LED), .ALU_OP(ALU_OP), .AB_SW(AB_SW), .F_LED_SW(F_LED_SW),
        .busy(busy), .done(done), .result(result), .zf(zf), .of(of)
    );

    always #5 clk = ~clk;

    // ALU top stub: muxes the programmed F byte or the flags onto LED; optional settle noise.
    always_comb begin
        case (F_LED_SW)
            3'd0:    led_true = stub_f[7:0];
            3'd1:    led_true = stub_f[15:8];
            3'd2:    led_true = stub_f[23:16];
            3'd3:    led_true = stub_f[31:24];
            3'd4:    led_true = {stub_zf, stub_mid, stub_of};
            default: led_true = 8'h00;
        endcase
    end
    assign LED = noise_on ? noise_val : led_true;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: a read is 25 cycles counted from the accept edge; lane = k/5,
    // and the last cycle of each lane is the one whose LED value is kept.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_k = 0; m_op = '0; m_ab = '0;
            m_acc = '0; m_res = '0; m_zf = 1'b0; m_of = 1'b0;
        end else if (m_busy) begin
            if (m_k == READ_CYC) begin
                m_busy = 1'b0;
            end else begin
                if (m_k % LANE_CYC == LANE_CYC - 1) begin
                    int lane;
                    lane = m_k / LANE_CYC;
                    if (lane < 4) begin
                        m_acc = m_acc | (((stub_f >> (8 * lane)) & 32'hFF) << (8 * lane));
                    end else begin
                        m_res = m_acc; m_zf = stub_zf; m_of = stub_of; m_ndone++;
                    end
                end
                m_k++;
            end
        end else if (start) begin
            m_busy = 1'b1; m_k = 0; m_op = op_in; m_ab = ab_in; m_acc = '0;
        end
        #1;
        if (done) n_done++;
        chk("busy",     32'(busy),     32'(m_busy));
        chk("done",     32'(done),     32'(m_busy && (m_k == READ_CYC)));
        chk("f_led_sw", 32'(F_LED_SW), 32'((m_busy && m_k < READ_CYC) ? m_k / LANE_CYC : 0));
        chk("alu_op",   32'(ALU_OP),   32'(m_op));
        chk("ab_sw",    32'(AB_SW),    32'(m_ab));
        chk("result",   result,        m_res);
        chk("zf",       32'(zf),       32'(m_zf));
        chk("of",       32'(of),       32'(m_of));
        noise_on  = noise_en && m_busy && (m_k < READ_CYC) && (m_k % LANE_CYC != LANE_CYC - 1);
        noise_val = 8'($urandom);
    end

    // One read; pulse_at > 0 re-pulses start with op 3'b111 that many cycles after the request.
    task automatic do_read(input logic [2:0] op, input logic [2:0] ab, input logic [31:0] f,
                           input logic fz, input logic fo, input logic noise,
                           input int pulse_at, output int lat);
        stub_f = f; stub_zf = fz; stub_of = fo; stub_mid = 6'($urandom); noise_en = noise;
        @(negedge clk);
        start = 1'b1; op_in = op; ab_in = ab;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            op_in = start ? 3'b111 : 3'($urandom);
            ab_in = 3'($urandom);
            if (done) begin
                lat = c - 1;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        noise_en = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] rf;
        rst_n = 1'b0; start = 1'b1; op_in = 3'b101; ab_in = 3'b010;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_op", 32'(ALU_OP), 32'd0);
        start = 1'b0; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        do_read(3'b000, 3'b001, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 0, lat);
        chk("t2_latency", 32'(lat), 32'd25);
        chk("t2_result", result, 32'h1234_5678);
        chk("t2_flags", 32'({zf, of}), 32'b01);

        do_read(3'b010, 3'b011, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, lat);
        chk("t3_result", result, 32'h0);
        chk("t3_flags", 32'({zf, of}), 32'b10);

        do_read(3'b100, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 0, lat);
        chk("t4_result", result, 32'hFFFF_FFFE);

        do_read(3'b001, 3'b000, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0, 7, lat);
        chk("t5_alu_op", 32'(ALU_OP), 32'b001);
        chk("t5_latency", 32'(lat), 32'd25);

        // Abort while lane 010 is being read.
        stub_f = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b1; op_in = 3'b011; ab_in = 3'b101;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("t6_lane_before_rst", 32'(F_LED_SW), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",   32'(busy), 32'd0);
        chk("t6_rst_lane",   32'(F_LED_SW), 32'd0);
        chk("t6_rst_result", result, 32'd0);
        chk("t6_rst_alu_op", 32'(ALU_OP), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(3'b110, 3'b001, 32'h0000_0038, 1'b0, 1'b0, 1'b0, 0, lat);
        chk("t6_result", result, 32'h0000_0038);
        chk("t6_latency", 32'(lat), 32'd25);

        // start held high: reads run back to back with one idle cycle between them.
        stub_f = 32'h0BAD_F00D; stub_zf = 1'b1; stub_of = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            op_in = 3'($urandom); ab_in = 3'($urandom);
        end
        start = 1'b0;
        for (int c = 0; c < 40 && m_busy; c++) @(negedge clk);
        chk("b2b_idle", 32'(m_busy || busy), 32'd0);
        chk("b2b_result", result, 32'h0BAD_F00D);

        for (int i = 0; i < 20; i++) begin
            rf = $urandom;
            do_read(3'($urandom), 3'($urandom), rf, 1'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(0, 24)), lat);
            chk("rnd_latency", 32'(lat), 32'd25);
            chk("rnd_result", result, rf);
        end

        chk("done_count", 32'(n_done), 32'(m_ndone));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
